// File: rtl/pay_bcd_conv.sv
// pay_bcd_conv: iterative double-dabble binary-to-BCD converter with saturation and overflow flag.
// Define PAY_BCD_LZB_EN to blank leading zero digits with 4'hF.
module pay_bcd_conv #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_fee,
    output logic                out_valid,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic                busy
);
    localparam int BW = 4 * DIGITS;
    localparam int MW = IN_W > BW ? IN_W : BW;
    localparam int CW = IN_W > 1 ? $clog2(IN_W) : 1;

    function automatic logic [MW-1:0] max_val();
        logic [MW-1:0] m;
        m = MW'(1);
        for (int i = 0; i < DIGITS; i++) m = m * MW'(10);
        return m - MW'(1);
    endfunction

    localparam logic [MW-1:0] MAX   = max_val();
    localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};
`ifdef PAY_BCD_LZB_EN
    localparam logic [BW-1:0] RST_BCD = {BW{1'b1}} << 4;
`else
    localparam logic [BW-1:0] RST_BCD = '0;
`endif

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state;
    logic [BW+IN_W-1:0]  sr;
    logic [BW+IN_W-1:0]  sh;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       res;
    logic [BW-1:0]       fin;
    logic [CW-1:0]       cnt;
    logic                ovf_pend;

    assign in_ready = state == IDLE;
    assign busy     = state == CONV;

    // Accumulator sits above the binary operand so one shift moves the binary MSB into BCD bit 0
    always_comb begin
        adj = sr[BW+IN_W-1:IN_W];
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = adj[4*k +: 4] >= 4'd5 ? adj[4*k +: 4] + 4'd3 : adj[4*k +: 4];
        sh  = {adj, sr[IN_W-1:0]} << 1;
        res = sh[BW+IN_W-1:IN_W];
        fin = res;
`ifdef PAY_BCD_LZB_EN
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (res[BW-1:4*k] == '0)
                fin[4*k +: 4] = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            bcd       <= RST_BCD;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    sr       <= {{BW{1'b0}}, in_fee};
                    cnt      <= '0;
                    ovf_pend <= MW'(in_fee) > MAX;
                    state    <= CONV;
                end
            end else begin
                sr  <= sh;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(IN_W - 1)) begin
                    bcd       <= ovf_pend ? NINES : fin;
                    ovf       <= ovf_pend;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_pay_bcd_conv.sv
// tb_pay_bcd_conv: directed tests for pay_bcd_conv against a decimal-arithmetic reference model.
module tb_pay_bcd_conv;
    localparam int IW   = 10;
    localparam int DG   = 3;
    localparam int MAXV = 999;
`ifdef PAY_BCD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [11:0] RSTV = LZB ? 12'hFF0 : 12'h000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, ovf, busy;
    logic [9:0]  in_fee;
    logic [11:0] bcd;

    logic        in2_valid, in2_ready, out2_valid, ovf2, busy2;
    logic [13:0] in2_fee;
    logic [15:0] bcd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pay_bcd_conv #(.IN_W(IW), .DIGITS(DG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fee(in_fee),
        .out_valid(out_valid), .bcd(bcd), .ovf(ovf), .busy(busy)
    );

    pay_bcd_conv #(.IN_W(14), .DIGITS(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready), .in_fee(in2_fee),
        .out_valid(out2_valid), .bcd(bcd2), .ovf(ovf2), .busy(busy2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference conversion: decimal digits by division, then saturation and blanking rules
    function automatic logic [11:0] conv(input int fee);
        logic [11:0] r;
        int v;
        bit lead;
        if (fee > MAXV) return 12'h999;
        v = fee;
        r = '0;
        for (int k = 0; k < DG; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        lead = LZB;
        for (int k = DG - 1; k > 0; k--) begin
            if (lead && r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
            else lead = 1'b0;
        end
        return r;
    endfunction

    logic        m_busy = 1'b0, m_ov = 1'b0, m_ovf = 1'b0;
    logic [11:0] m_bcd = 12'h000;
    int          m_left = 0, m_fee = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_ov   = 1'b0;
            m_bcd  = RSTV;
            m_ovf  = 1'b0;
        end else begin
            m_ov = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_ov   = 1'b1;
                    m_bcd  = conv(m_fee);
                    m_ovf  = m_fee > MAXV;
                end
            end else if (in_valid) begin
                m_busy = 1'b1;
                m_left = IW;
                m_fee  = int'(in_fee);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("bcd", bcd, m_bcd);
        chk("ovf", ovf, m_ovf);
    end

    task automatic send(input int fee);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_fee   = 10'(fee);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [11:0] eb, input logic eo);
        int cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, cyc - 1, IW);
        chk({nm, " bcd"}, bcd, eb);
        chk({nm, " ovf"}, ovf, eo);
        @(negedge clk);
        chk({nm, " pulse width"}, out_valid, 1'b0);
    endtask

    task automatic run(input string nm, input int fee, input logic [11:0] eb, input logic eo);
        send(fee);
        wait_done(nm, eb, eo);
    endtask

    task automatic run2(input string nm, input int fee, input logic [15:0] eb, input logic eo);
        int cyc = 1;
        in2_valid = 1'b1;
        in2_fee   = 14'(fee);
        @(negedge clk);
        in2_valid = 1'b0;
        while (!out2_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, cyc - 1, 14);
        chk({nm, " bcd"}, bcd2, eb);
        chk({nm, " ovf"}, ovf2, eo);
        @(negedge clk);
    endtask

    initial begin
        int cyc, nb, pulses;
        rst = 1'b1;
        in_valid = 1'b0;
        in_fee = '0;
        in2_valid = 1'b0;
        in2_fee = '0;
        repeat (3) @(negedge clk);
        chk("reset bcd", bcd, RSTV);
        chk("reset ovf", ovf, 1'b0);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        chk("model 47", conv(47), LZB ? 12'hF47 : 12'h047);
        chk("model 0", conv(0), LZB ? 12'hFF0 : 12'h000);
        chk("model 1023", conv(1023), 12'h999);
        chk("model 305", conv(305), 12'h305);

        run("fee0", 0, LZB ? 12'hFF0 : 12'h000, 1'b0);
        run("fee47", 47, LZB ? 12'hF47 : 12'h047, 1'b0);
        run("fee999", 999, 12'h999, 1'b0);
        run("fee1000", 1000, 12'h999, 1'b1);
        run("fee1023", 1023, 12'h999, 1'b1);
        run("fee5", 5, LZB ? 12'hFF5 : 12'h005, 1'b0);
        run("fee1023b", 1023, 12'h999, 1'b1);

        send(305);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort bcd", bcd, RSTV);
        chk("abort ovf", ovf, 1'b0);
        chk("abort out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", in_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        pulses = 0;
        for (int i = 0; i < IW + 4; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort no pulse", pulses, 0);
        run("fee305", 305, 12'h305, 1'b0);

        in_valid = 1'b1;
        in_fee   = 10'd123;
        @(negedge clk);
        in_fee = 10'd456;
        cyc = 1;
        nb  = 0;
        while (!out_valid && cyc < 40) begin
            if (busy && !in_ready) nb++;
            @(negedge clk);
            cyc++;
        end
        chk("b2b latency", cyc - 1, IW);
        chk("b2b busy cycles", nb, IW);
        chk("b2b bcd123", bcd, 12'h123);
        chk("b2b ready at pulse", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b hold 123", bcd, 12'h123);
        wait_done("b2b456", 12'h456, 1'b0);

        run2("w14 9999", 9999, 16'h9999, 1'b0);
        run2("w14 16383", 16383, 16'h9999, 1'b1);
        run2("w14 1234", 1234, 16'h1234, 1'b0);
        run2("w14 7", 7, LZB ? 16'hFFF7 : 16'h0007, 1'b0);
        chk("w14 idle", in2_ready, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pay_bcd_conv.md
Name: pay_bcd_conv

Overview:
Parametrised, sequential binary-to-BCD converter for the taximeter fee display path. It takes a binary fee from the fare calculator through a valid/ready handshake and runs an iterative shift-and-add-3 (double dabble) conversion, one bit per cycle. It presents DIGITS packed BCD digits to the seven-segment decoder stage, with saturation and an overflow flag. This replaces fixed 3-digit divide/modulo conversion and removes the wide combinational dividers.

Parameters:
IN_W, 10, width of the binary fee input (must be >= 1)
DIGITS, 3, number of BCD digits produced (must be >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_fee is valid this cycle
in_ready  output  1  block can accept a new fee (high only in IDLE)
in_fee  input  IN_W  binary fee value
out_valid  output  1  one-cycle pulse: bcd/ovf just updated
bcd  output  4*DIGITS  packed BCD result; digit k in bits [4k+3:4k], k=0 is the units digit
ovf  output  1  last accepted fee exceeded 10^DIGITS-1; bcd saturated
busy  output  1  conversion in progress (state CONV)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, bcd=0, ovf=0, out_valid=0, internal shift/count registers cleared. Any conversion in flight is aborted with no out_valid.
- MAX = 10^DIGITS-1, elaboration-time constant. Compare in_fee against MAX at full width, no truncation.
- States: IDLE, CONV.
  - in_ready = (state==IDLE); busy = (state==CONV); both decoded directly from the state register.
- IDLE: on an edge with in_valid=1 (implicitly in_ready=1):
  - Load the binary shift register with in_fee.
  - Clear the BCD accumulator (4*DIGITS bits) and set the iteration count to 0.
  - Latch ovf_pend = (in_fee > MAX).
  - Go to CONV.
  - in_fee is ignored whenever in_ready=0.
- CONV: each edge performs one iteration:
  - Add 3 to every accumulator digit >= 5.
  - Shift {accumulator, binary} left by 1 (MSB of binary enters bit 0 of the accumulator).
  - Increment the count.
- Completion: on the edge that performs iteration IN_W-1:
  - bcd <= final accumulator, or all digits 4'h9 if ovf_pend.
  - ovf <= ovf_pend; out_valid <= 1; state <= IDLE.
- Latency: out_valid is high exactly IN_W cycles after the accepting edge and lasts one cycle. in_ready is high again in that same cycle, so a new fee may be accepted while out_valid=1. Throughput is one conversion per IN_W cycles.
- bcd and ovf hold their last values between completions and never show intermediate accumulator values.
- Accumulator digits above the range needed by IN_W stay 0. If 2^IN_W-1 <= MAX, ovf is constant 0.
- Reset released mid-stream: the first accept happens only on an edge with rst low.

Optional Feature:
Macro PAY_BCD_LZB_EN (leading-zero blanking).
- Defined: at completion, every leading zero digit above digit 0 is replaced by 4'hF (blank code for the segment decoder). Digit 0 is never blanked. Saturated output (all 9s) is unaffected. Reset value of bcd becomes {DIGITS-1 x 4'hF, 4'h0}.
- Not defined: digits are output as plain BCD, with zeros shown and reset value 0.

Test Plan:
- Accept in_fee=0 -> after 10 cycles out_valid=1 for 1 cycle, bcd=12'h000 (LZB: 12'hFF0), ovf=0.
- Accept in_fee=47 -> bcd=12'h047 (LZB: 12'hF47); accept 999 -> bcd=12'h999, ovf=0.
- Accept in_fee=1023 -> bcd=12'h999, ovf=1; then accept 5 -> bcd=12'h005 (LZB: 12'hFF5), ovf=0.
- Accept 305, assert rst at cycle 5 of CONV -> bcd=0, ovf=0, no out_valid, in_ready=1 after release; re-accept 305 -> bcd=12'h305 after 10 cycles.
- Hold in_valid=1 with 123 then 456 (second presented during CONV) -> in_ready=0 and busy=1 for the 10 CONV cycles; 456 accepted in the out_valid cycle of 123; bcd holds 12'h123 until the next pulse shows 12'h456.
- Rebuild with IN_W=14, DIGITS=4 -> in_fee=9999 gives bcd=16'h9999, ovf=0; in_fee=16383 gives bcd=16'h9999, ovf=1; latency 14 cycles.
